// File: rtl/uart_packet_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_packet_framer
// Brief    : Streams one framed packet (ctrl, length, headers, RAM records,
//            optional checksum) byte-by-byte into a UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module uart_packet_framer #(
    parameter int N_HDR     = 5,
    parameter int REC_BYTES = 10,
    parameter int ADDR_W    = 14,
    parameter int RD_LAT    = 2,
    parameter int CSUM_EN   = 1
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          start,
    input  logic                                          abort,
    input  logic [7:0]                                    ctrl_word,
    input  logic [15:0]                                   ndata,
    input  logic [((N_HDR > 0) ? 32*N_HDR : 32)-1:0]      hdr_data,
    output logic [ADDR_W-1:0]                             rd_addr,
    output logic                                          rd_en,
    input  logic [8*REC_BYTES-1:0]                        rd_data,
    output logic [7:0]                                    tx_data,
    output logic                                          tx_valid,
    input  logic                                          tx_ready,
    output logic                                          busy,
    output logic                                          done
);

    localparam int         HDR_W    = (N_HDR > 0) ? 32*N_HDR : 32;
    localparam int         REC_W    = 8*REC_BYTES;
    localparam logic [5:0] HDR_LAST = 6'(4*N_HDR - 1);
    localparam logic [5:0] REC_LAST = 6'(REC_BYTES - 1);
    localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_CTRL     = 4'd1,
        S_LEN_HI   = 4'd2,
        S_LEN_LO   = 4'd3,
        S_HDR      = 4'd4,
        S_RD_ISSUE = 4'd5,
        S_RD_WAIT  = 4'd6,
        S_REC      = 4'd7,
        S_CSUM     = 4'd8,
        S_DONE     = 4'd9
    } state_t;

    state_t              state_q,    state_d;
    logic [7:0]          tx_data_q,  tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                rd_en_q,    rd_en_d;
    logic                done_q,     done_d;
    logic [ADDR_W-1:0]   rd_addr_q,  rd_addr_d;
    logic [7:0]          csum_q,     csum_d;
    logic [5:0]          byte_cnt_q, byte_cnt_d;
    logic [2:0]          lat_cnt_q,  lat_cnt_d;
    logic [15:0]         rec_idx_q,  rec_idx_d;
    logic [15:0]         ndata_q,    ndata_d;
    logic [HDR_W-1:0]    hdr_q,      hdr_d;
    logic [REC_W-1:0]    rec_sh_q,   rec_sh_d;

    logic        xfer;
    logic        enter_body;
    logic        enter_tail;
    logic [15:0] len;

    // Product held at 24 bits before the sum is cut to the 16-bit field.
    assign len  = 16'(24'(ndata_q) * 24'(REC_BYTES) + 24'(4 * N_HDR) + 24'(CSUM_EN));
    assign xfer = tx_valid_q && tx_ready;

    // Header byte idx: word idx/4 (word 0 first), byte within word MSB first.
    function automatic logic [7:0] hdr_byte(input logic [HDR_W-1:0] h, input logic [5:0] idx);
        return 8'(h >> (32*int'(idx[5:2]) + 24 - 8*int'(idx[1:0])));
    endfunction

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        rd_en_d    = 1'b0;
        done_d     = 1'b0;
        rd_addr_d  = rd_addr_q;
        byte_cnt_d = byte_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        rec_idx_d  = rec_idx_q;
        ndata_d    = ndata_q;
        hdr_d      = hdr_q;
        rec_sh_d   = rec_sh_q;
        enter_body = 1'b0;
        enter_tail = 1'b0;
        csum_d     = (xfer && state_q != S_CSUM) ? csum_q + tx_data_q : csum_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ndata_d    = ndata;
                    hdr_d      = hdr_data;
                    csum_d     = 8'd0;
                    rd_addr_d  = '0;
                    tx_data_d  = ctrl_word;
                    tx_valid_d = 1'b1;
                    state_d    = S_CTRL;
                end
            end
            S_CTRL: begin
                if (xfer) begin
                    tx_data_d = len[15:8];
                    state_d   = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    tx_data_d = len[7:0];
                    state_d   = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    if (N_HDR > 0) begin
                        byte_cnt_d = 6'd0;
                        tx_data_d  = hdr_byte(hdr_q, 6'd0);
                        state_d    = S_HDR;
                    end else begin
                        enter_body = 1'b1;
                    end
                end
            end
            S_HDR: begin
                if (xfer) begin
                    if (byte_cnt_q == HDR_LAST) begin
                        enter_body = 1'b1;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 6'd1;
                        tx_data_d  = hdr_byte(hdr_q, byte_cnt_q + 6'd1);
                    end
                end
            end
            S_RD_ISSUE: begin
                lat_cnt_d = 3'd0;
                state_d   = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    rec_sh_d   = rd_data;
                    tx_data_d  = rd_data[REC_W-1 -: 8];
                    tx_valid_d = 1'b1;
                    byte_cnt_d = 6'd0;
                    state_d    = S_REC;
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end
            S_REC: begin
                if (xfer) begin
                    if (byte_cnt_q == REC_LAST) begin
                        if (rec_idx_q != ndata_q - 16'd1) begin
                            rec_idx_d  = rec_idx_q + 16'd1;
                            rd_addr_d  = rd_addr_q + 1'b1;
                            rd_en_d    = 1'b1;
                            tx_valid_d = 1'b0;
                            state_d    = S_RD_ISSUE;
                        end else begin
                            rd_addr_d  = '0;
                            enter_tail = 1'b1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 6'd1;
                        rec_sh_d   = rec_sh_q << 8;
                        tx_data_d  = rec_sh_d[REC_W-1 -: 8];
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    tx_valid_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase

        if (enter_body) begin
            if (ndata_q != 16'd0) begin
                rec_idx_d  = 16'd0;
                rd_addr_d  = '0;
                rd_en_d    = 1'b1;
                tx_valid_d = 1'b0;
                state_d    = S_RD_ISSUE;
            end else begin
                enter_tail = 1'b1;
            end
        end

        if (enter_tail) begin
            if (CSUM_EN != 0) begin
                tx_data_d  = csum_d;
                tx_valid_d = 1'b1;
                state_d    = S_CSUM;
            end else begin
                tx_valid_d = 1'b0;
                done_d     = 1'b1;
                state_d    = S_DONE;
            end
        end

        if (abort) begin
            tx_valid_d = 1'b0;
            rd_en_d    = 1'b0;
            rd_addr_d  = '0;
            done_d     = 1'b0;
            state_d    = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            rd_en_q    <= 1'b0;
            done_q     <= 1'b0;
            rd_addr_q  <= '0;
            csum_q     <= 8'd0;
            byte_cnt_q <= 6'd0;
            lat_cnt_q  <= 3'd0;
            rec_idx_q  <= 16'd0;
            ndata_q    <= 16'd0;
            hdr_q      <= '0;
            rec_sh_q   <= '0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            rd_en_q    <= rd_en_d;
            done_q     <= done_d;
            rd_addr_q  <= rd_addr_d;
            csum_q     <= csum_d;
            byte_cnt_q <= byte_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            rec_idx_q  <= rec_idx_d;
            ndata_q    <= ndata_d;
            hdr_q      <= hdr_d;
            rec_sh_q   <= rec_sh_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign rd_en    = rd_en_q;
    assign rd_addr  = rd_addr_q;
    assign done     = done_q;
    assign busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_packet_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_packet_framer
// Brief    : Scoreboard bench for three framer configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_packet_framer;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // dut0: defaults (N_HDR=5, REC_BYTES=10, RD_LAT=2, CSUM_EN=1)
    logic st0 = 0, ab0 = 0, tr0 = 1;
    logic [7:0] ctrl0 = 0;  logic [15:0] nd0 = 0;  logic [159:0] hdr0 = '0;
    logic [13:0] ra0;  logic re0;  logic [79:0] rdd0;  logic [7:0] td0;  logic tv0, bz0, dn0;
    // dut1: N_HDR=0, REC_BYTES=3, RD_LAT=1, CSUM_EN=0
    logic st1 = 0, tr1 = 1;
    logic [7:0] ctrl1 = 0;  logic [15:0] nd1 = 0;  logic [31:0] hdr1 = '0;
    logic [13:0] ra1;  logic re1;  logic [23:0] rdd1;  logic [7:0] td1;  logic tv1, bz1, dn1;
    // dut2: N_HDR=1, REC_BYTES=1, RD_LAT=4, CSUM_EN=1
    logic st2 = 0, tr2 = 1;
    logic [7:0] ctrl2 = 0;  logic [15:0] nd2 = 0;  logic [31:0] hdr2 = '0;
    logic [13:0] ra2;  logic re2;  logic [7:0] rdd2;  logic [7:0] td2;  logic tv2, bz2, dn2;

    uart_packet_framer u_dut0 (
        .clk(clk), .reset(reset), .start(st0), .abort(ab0), .ctrl_word(ctrl0), .ndata(nd0),
        .hdr_data(hdr0), .rd_addr(ra0), .rd_en(re0), .rd_data(rdd0), .tx_data(td0),
        .tx_valid(tv0), .tx_ready(tr0), .busy(bz0), .done(dn0));

    uart_packet_framer #(.N_HDR(0), .REC_BYTES(3), .RD_LAT(1), .CSUM_EN(0)) u_dut1 (
        .clk(clk), .reset(reset), .start(st1), .abort(1'b0), .ctrl_word(ctrl1), .ndata(nd1),
        .hdr_data(hdr1), .rd_addr(ra1), .rd_en(re1), .rd_data(rdd1), .tx_data(td1),
        .tx_valid(tv1), .tx_ready(tr1), .busy(bz1), .done(dn1));

    uart_packet_framer #(.N_HDR(1), .REC_BYTES(1), .RD_LAT(4), .CSUM_EN(1)) u_dut2 (
        .clk(clk), .reset(reset), .start(st2), .abort(1'b0), .ctrl_word(ctrl2), .ndata(nd2),
        .hdr_data(hdr2), .rd_addr(ra2), .rd_en(re2), .rd_data(rdd2), .tx_data(td2),
        .tx_valid(tv2), .tx_ready(tr2), .busy(bz2), .done(dn2));

    // Record at address a: byte j = 16*a + j. Data is only valid in the single
    // cycle ending exactly RD_LAT edges after rd_en was sampled; 0xEE otherwise.
    function automatic logic [127:0] rec_of(input int a);
        logic [127:0] r;
        for (int j = 0; j < 16; j++) r[8*j +: 8] = 8'(16*a + j);
        return r;
    endfunction

    logic [1:0]  p0v = '0;  logic [13:0] p0a [2];
    logic        p1v = 1'b0; logic [13:0] p1a;
    logic [3:0]  p2v = '0;  logic [13:0] p2a [4];
    logic [127:0] m0, m1, m2;

    always @(posedge clk) begin
        p0v <= {p0v[0], re0};  p0a[1] <= p0a[0];  p0a[0] <= ra0;
        p1v <= re1;            p1a <= ra1;
        p2v <= {p2v[2:0], re2};
        p2a[3] <= p2a[2];  p2a[2] <= p2a[1];  p2a[1] <= p2a[0];  p2a[0] <= ra2;
    end

    always_comb begin
        m0 = rec_of(int'(p0a[1]));
        m1 = rec_of(int'(p1a));
        m2 = rec_of(int'(p2a[3]));
        rdd0 = p0v[1] ? m0[79:0] : {10{8'hEE}};
        rdd1 = p1v    ? m1[23:0] : {3{8'hEE}};
        rdd2 = p2v[3] ? m2[7:0]  : 8'hEE;
    end

    int re1_cnt = 0;
    always @(negedge clk) if (re1 === 1'b1) re1_cnt <= re1_cnt + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard queues and monitors
    logic [7:0] q0[$], q1[$], q2[$];
    logic [7:0] e0, e1, e2;

    always @(negedge clk) begin
        if (tv0 === 1'b1 && tr0 === 1'b1) begin
            if (q0.size() == 0) chk("dut0_extra_byte", {24'd0, td0}, 32'h100);
            else begin e0 = q0.pop_front(); chk("dut0_byte", {24'd0, td0}, {24'd0, e0}); end
        end
        if (tv1 === 1'b1 && tr1 === 1'b1) begin
            if (q1.size() == 0) chk("dut1_extra_byte", {24'd0, td1}, 32'h100);
            else begin e1 = q1.pop_front(); chk("dut1_byte", {24'd0, td1}, {24'd0, e1}); end
        end
        if (tv2 === 1'b1 && tr2 === 1'b1) begin
            if (q2.size() == 0) chk("dut2_extra_byte", {24'd0, td2}, 32'h100);
            else begin e2 = q2.pop_front(); chk("dut2_byte", {24'd0, td2}, {24'd0, e2}); end
        end
    end

    // A stalled byte must persist unchanged into the next cycle (abort excepted).
    logic stall0 = 1'b0, abt0_prev = 1'b0;
    logic [7:0] held0 = 8'd0;
    always @(negedge clk) begin
        if (stall0 && !abt0_prev && !reset) begin
            chk("dut0_stall_valid", {31'd0, tv0}, 32'd1);
            chk("dut0_stall_data", {24'd0, td0}, {24'd0, held0});
        end
        stall0    <= (tv0 === 1'b1) && (tr0 === 1'b0);
        held0     <= td0;
        abt0_prev <= ab0;
    end

    function automatic logic get_dn(input int w);
        case (w) 0: return dn0; 1: return dn1; default: return dn2; endcase
    endfunction
    function automatic logic get_tv(input int w);
        case (w) 0: return tv0; 1: return tv1; default: return tv2; endcase
    endfunction
    function automatic logic get_bz(input int w);
        case (w) 0: return bz0; 1: return bz1; default: return bz2; endcase
    endfunction
    function automatic logic [7:0] get_td(input int w);
        case (w) 0: return td0; 1: return td1; default: return td2; endcase
    endfunction
    function automatic int qsize(input int w);
        case (w) 0: return q0.size(); 1: return q1.size(); default: return q2.size(); endcase
    endfunction

    task automatic set_in(input int w, input logic s, input logic [7:0] c,
                          input logic [15:0] n, input logic [159:0] h);
        case (w)
            0: begin st0 = s; ctrl0 = c; nd0 = n; hdr0 = h; end
            1: begin st1 = s; ctrl1 = c; nd1 = n; hdr1 = h[31:0]; end
            default: begin st2 = s; ctrl2 = c; nd2 = n; hdr2 = h[31:0]; end
        endcase
    endtask

    task automatic set_rdy(input int w, input logic v);
        case (w) 0: tr0 = v; 1: tr1 = v; default: tr2 = v; endcase
    endtask

    // Hand-built expected stream for the configuration of dut w.
    task automatic push_pkt(input int w, input logic [7:0] c, input int nd, input logic [159:0] h);
        int nh, rb, cs;
        logic [7:0] bq[$];
        logic [7:0] sum;
        logic [15:0] len;
        logic [127:0] rec;
        case (w)
            0: begin nh = 5; rb = 10; cs = 1; end
            1: begin nh = 0; rb = 3;  cs = 0; end
            default: begin nh = 1; rb = 1; cs = 1; end
        endcase
        len = 16'(nh*4 + nd*rb + cs);
        bq.push_back(c);
        bq.push_back(len[15:8]);
        bq.push_back(len[7:0]);
        for (int i = 0; i < nh; i++)
            for (int b = 3; b >= 0; b--) bq.push_back(h[32*i + 8*b +: 8]);
        for (int k = 0; k < nd; k++) begin
            rec = rec_of(k);
            for (int j = rb - 1; j >= 0; j--) bq.push_back(rec[8*j +: 8]);
        end
        sum = 8'd0;
        foreach (bq[i]) sum = sum + bq[i];
        if (cs != 0) bq.push_back(sum);
        foreach (bq[i]) begin
            case (w) 0: q0.push_back(bq[i]); 1: q1.push_back(bq[i]); default: q2.push_back(bq[i]); endcase
        end
    endtask

    task automatic run(input int w, input logic [7:0] c, input logic [15:0] n, input logic [159:0] h,
                       input bit rnd, input int exp_cyc, input bit poke);
        int k;
        push_pkt(w, c, int'(n), h);
        @(posedge clk); #1;
        set_in(w, 1'b1, c, n, h);
        @(posedge clk); #1;
        set_in(w, 1'b0, ~c, n + 16'd7, ~h);
        chk("latency_valid", {31'd0, get_tv(w)}, 32'd1);
        chk("latency_ctrl", {24'd0, get_td(w)}, {24'd0, c});
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
            if (rnd) set_rdy(w, 1'($urandom_range(0, 1)));
            if (poke && k == 5) set_in(w, 1'b1, 8'h99, 16'd2, '1);
            if (poke && k == 7) set_in(w, 1'b0, 8'h00, 16'd0, '0);
        end while (get_dn(w) !== 1'b1 && k < 3000);
        chk("done_seen", {31'd0, get_dn(w)}, 32'd1);
        if (exp_cyc > 0) chk("packet_cycles", k, exp_cyc);
        set_rdy(w, 1'b1);
        @(posedge clk); #1;
        chk("done_one_cycle", {31'd0, get_dn(w)}, 32'd0);
        chk("idle_after_done", {31'd0, get_bz(w)}, 32'd0);
        chk("queue_drained", qsize(w), 32'd0);
        if (poke) begin
            repeat (3) @(posedge clk);
            #1;
            chk("start_while_busy_ignored", {31'd0, get_bz(w)}, 32'd0);
        end
    endtask

    localparam logic [159:0] H5 = {32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    localparam logic [159:0] HB = {32'h0, 32'h0, 32'h0, 32'h0, 32'hA1B2C3D4};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int dn_seen;
        #2 reset = 1'b1;
        #1;
        chk("rst_rd_addr", {18'd0, ra0}, 32'd0);
        chk("rst_rd_en", {31'd0, re0}, 32'd0);
        chk("rst_tx_data", {24'd0, td0}, 32'd0);
        chk("rst_tx_valid", {31'd0, tv0}, 32'd0);
        chk("rst_busy", {31'd0, bz0}, 32'd0);
        chk("rst_done", {31'd0, dn0}, 32'd0);
        chk("rst_dut1_valid", {31'd0, tv1}, 32'd0);
        chk("rst_dut2_busy", {31'd0, bz2}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Full default packet, then the same packet with random back-pressure.
        run(0, 8'h63, 16'd2, H5, 1'b0, 50, 1'b0);
        run(0, 8'h63, 16'd2, H5, 1'b1, 0, 1'b0);

        // No headers, no records, no checksum: 63 00 00 and no reads.
        run(1, 8'h63, 16'd0, '0, 1'b0, 3, 1'b0);
        chk("dut1_no_rd_en", re1_cnt, 32'd0);
        // RD_LAT=1 and RD_LAT=4 record capture.
        run(1, 8'h81, 16'd2, '0, 1'b0, 13, 1'b0);
        run(2, 8'h5A, 16'd3, HB, 1'b0, 26, 1'b0);

        // Abort during record 1.
        push_pkt(0, 8'h63, 2, H5);
        @(posedge clk); #1 set_in(0, 1'b1, 8'h63, 16'd2, H5);
        @(posedge clk); #1 set_in(0, 1'b0, 8'h00, 16'd0, '0);
        k = 0;
        while (!(ra0 == 14'd1 && tv0 === 1'b1) && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        chk("abort_reached_rec1", {31'd0, (ra0 == 14'd1 && tv0 === 1'b1)}, 32'd1);
        ab0 = 1'b1;
        tr0 = 1'b0;
        @(posedge clk); #1;
        ab0 = 1'b0;
        tr0 = 1'b1;
        chk("abort_tx_valid", {31'd0, tv0}, 32'd0);
        chk("abort_busy", {31'd0, bz0}, 32'd0);
        chk("abort_rd_addr", {18'd0, ra0}, 32'd0);
        chk("abort_rd_en", {31'd0, re0}, 32'd0);
        chk("abort_remaining_bytes", q0.size(), 32'd11);
        q0.delete();
        dn_seen = 0;
        repeat (4) begin
            if (dn0 === 1'b1) dn_seen++;
            @(posedge clk); #1;
        end
        chk("abort_no_done", dn_seen, 32'd0);
        run(0, 8'h3C, 16'd1, H5, 1'b0, 37, 1'b0);

        // Asynchronous reset in the middle of the header.
        push_pkt(0, 8'h63, 2, H5);
        @(posedge clk); #1 set_in(0, 1'b1, 8'h63, 16'd2, H5);
        @(posedge clk); #1 set_in(0, 1'b0, 8'h00, 16'd0, '0);
        repeat (6) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_tx_valid", {31'd0, tv0}, 32'd0);
        chk("mid_rst_tx_data", {24'd0, td0}, 32'd0);
        chk("mid_rst_busy", {31'd0, bz0}, 32'd0);
        chk("mid_rst_rd_addr", {18'd0, ra0}, 32'd0);
        chk("mid_rst_rd_en", {31'd0, re0}, 32'd0);
        chk("mid_rst_done", {31'd0, dn0}, 32'd0);
        q0.delete();
        @(posedge clk); #1 reset = 1'b0;

        // Start pulsed while busy must not disturb or re-trigger the packet.
        run(0, 8'h11, 16'd1, H5, 1'b0, 37, 1'b1);

        chk("final_q0_empty", q0.size(), 32'd0);
        chk("final_q1_empty", q1.size(), 32'd0);
        chk("final_q2_empty", q2.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_packet_framer.md
# uart_packet_framer

Parametrised packet framer for the serial uplink. On a start request it snapshots a control byte, a record count and `N_HDR` 32-bit header words. It then streams one framed packet, one byte per handshake, into the byte-level UART transmitter: control byte, 16-bit length, header words, `ndata` records read from block RAM, and a checksum. It generalises the fixed 5-word / 10-byte-record sequencer to any header count, record width and RAM read latency. It adds flow control, abort and an integrity trailer.

## Interface
Parameters:
- `N_HDR`, default 5: number of 32-bit header words sent; range 0..15.
- `REC_BYTES`, default 10: bytes per RAM record; range 1..16.
- `ADDR_W`, default 14: RAM address width.
- `RD_LAT`, default 2: RAM read latency in cycles, counted from the `rd_en` edge to valid `rd_data`; range 1..4.
- `CSUM_EN`, default 1: 1 appends a checksum byte; 0 omits it.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: request one packet; sampled only in IDLE.
- `abort`, in, 1: synchronous cancel of the packet in progress.
- `ctrl_word`, in, 8: control byte for the packet.
- `ndata`, in, 16: number of RAM records to send.
- `hdr_data`, in, 32*N_HDR: header words; word 0 is in bits [31:0].
- `rd_addr`, out, ADDR_W: RAM read address.
- `rd_en`, out, 1: one-cycle read strobe.
- `rd_data`, in, 8*REC_BYTES: RAM record.
- `tx_data`, out, 8: byte to the UART transmitter.
- `tx_valid`, out, 1: `tx_data` is valid.
- `tx_ready`, in, 1: transmitter accepts the byte.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse after the last byte is accepted.

## Operation
- Reset values: `rd_addr`=0, `rd_en`=0, `tx_data`=0, `tx_valid`=0, `busy`=0, `done`=0, state=IDLE.
- State sequence: IDLE -> CTRL -> LEN_HI -> LEN_LO -> HDR -> RD_ISSUE -> RD_WAIT -> REC -> CSUM -> DONE -> IDLE.
- IDLE with `start`=1:
  - latch `ctrl_word`, `ndata` and `hdr_data`;
  - clear the checksum accumulator;
  - set `rd_addr`=0;
  - go to CTRL.
- Inputs are not re-sampled during a packet.
- Length field, 16-bit and truncating: `N_HDR*4 + ndata*REC_BYTES + CSUM_EN`. The product is computed at 24 bits and the sum is truncated to 16 bits. Software guarantees no overflow.
- Every multi-byte field is sent MSB first. Header words go in order 0..N_HDR-1. Each record goes from `rd_data` byte REC_BYTES-1 down to byte 0.
- HDR is skipped when `N_HDR`=0. RD_ISSUE/RD_WAIT/REC are skipped when `ndata`=0, going straight to CSUM (or to DONE when `CSUM_EN`=0).
- RD_ISSUE pulses `rd_en` for one cycle. RD_WAIT counts `RD_LAT` cycles, then latches `rd_data` into a shift register. REC emits `REC_BYTES` bytes.
- After the last byte of record k:
  - if k < `ndata`-1: `rd_addr` increments and the state returns to RD_ISSUE;
  - otherwise: `rd_addr` goes to 0 and the state goes to CSUM.
- Checksum: 8-bit modulo-256 sum of every accepted byte from CTRL through the last record byte. CSUM sends the sum unchanged.
- DONE pulses `done` for one cycle and returns to IDLE. In DONE, `busy` is still 1.
- `abort` has priority over everything except `reset`. On the next edge:
  - go to IDLE;
  - `tx_valid`=0, `rd_en`=0, `rd_addr`=0;
  - no `done` pulse.
- `start` while `busy` is ignored.

## Timing
- Handshake: a byte transfers on an edge where `tx_valid` and `tx_ready` are both 1.
  - While `tx_valid`=1 and `tx_ready`=0, `tx_data` is held stable.
  - `tx_valid` never drops without a transfer, except on abort or reset.
- Latency: `start` sampled at edge k gives `tx_valid`=1 with `ctrl_word` from cycle k+1.
- Back-to-back bytes within CTRL, LEN, HDR and REC: with `tx_ready` held at 1, one byte transfers per cycle.
- Record gap: each record adds `RD_LAT`+1 idle cycles with `tx_valid`=0.
- Packet length with `tx_ready`=1: `3 + 4*N_HDR + ndata*(REC_BYTES+RD_LAT+1) + CSUM_EN` cycles from the first `tx_valid` to the last transfer. `done` follows on the next cycle.
- `reset` asserted mid-packet: all outputs go to their reset values immediately (asynchronously), and the partial packet is dropped.

## Test plan
- Defaults, `ndata`=2, `ctrl_word`=0x63, header words 0x00000001..0x00000005, RAM[0]=0x00..09, RAM[1]=0x10..19, `tx_ready`=1:
  - required stream: 63 00 29 (length 41), then 20 header bytes, then 20 record bytes MSB-first, then the correct checksum;
  - `done` one cycle after the last byte.
- Same packet with `tx_ready` toggled pseudo-randomly: byte stream is identical; `tx_data` is stable during every stall; no byte is duplicated or dropped.
- `ndata`=0, `N_HDR`=0, `CSUM_EN`=0: stream is exactly 63 00 00; `rd_en` never pulses.
- `RD_LAT`=1 and `RD_LAT`=4: `rd_data` is captured exactly `RD_LAT` cycles after `rd_en`; no earlier capture; bytes correct.
- `abort` during record 1:
  - on the next cycle: `tx_valid`=0, `busy`=0, `rd_addr`=0, no `done` pulse;
  - a subsequent `start` gives a full correct packet.
- `reset` pulsed asynchronously mid-header: outputs reach their reset values before the next edge; `start` asserted while busy in a separate run has no effect.
